// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and sticky
// overrun / framing-error flags for the CPU load path.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          serial_in,
  output logic [7:0]    data_out,
  output logic          data_out_valid,
  input  logic          data_out_ready,
  output logic [AW:0]   fifo_count,
  output logic          overrun,
  output logic          framing_err,
  input  logic          err_clear
);

  localparam int SYMBOL = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE = SYMBOL / 2;
  localparam int CW     = $clog2(SYMBOL + 1);
  localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL - 1);
  localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_r;
  logic            rx_meta_r;
  logic            rx_sync_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            push_r;
  logic            ferr_pulse_r;

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     fifo_count_r;
  logic            overrun_r;
  logic            framing_err_r;

  logic            full_s;
  logic            pop_s;
  logic            wr_en_s;

  // Two-flop synchroniser; the line idles high so reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= serial_in;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM: start is confirmed at mid-bit, so data bits are sampled mid-symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      push_r       <= 1'b0;
      ferr_pulse_r <= 1'b0;
    end else begin
      push_r       <= 1'b0;
      ferr_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (!rx_sync_r) state_r <= START;
        end
        START: begin
          if (cnt_r == SAMP_LAST) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            state_r   <= rx_sync_r ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == SYM_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_sync_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) state_r <= STOP;
            bit_idx_r <= bit_idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_r == SYM_LAST) begin
            cnt_r        <= '0;
            state_r      <= IDLE;
            push_r       <= rx_sync_r;
            ferr_pulse_r <= ~rx_sync_r;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign full_s  = (fifo_count_r == DEPTH_C);
  assign pop_s   = data_out_valid & data_out_ready;
  assign wr_en_s = push_r & (~full_s | pop_s);

  // FIFO storage, pointers and occupancy; a pop frees the slot a full-FIFO push reuses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      if (wr_en_s && !pop_s)      fifo_count_r <= fifo_count_r + (AW + 1)'(1);
      else if (pop_s && !wr_en_s) fifo_count_r <= fifo_count_r - (AW + 1)'(1);
      else                        fifo_count_r <= fifo_count_r;
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_r     <= 1'b0;
      framing_err_r <= 1'b0;
    end else begin
      if (push_r && full_s && !pop_s) overrun_r <= 1'b1;
      else if (err_clear)             overrun_r <= 1'b0;
      else                            overrun_r <= overrun_r;
      if (ferr_pulse_r)    framing_err_r <= 1'b1;
      else if (err_clear)  framing_err_r <= 1'b0;
      else                 framing_err_r <= framing_err_r;
    end
  end

  // Head byte shown combinationally; forced to zero while empty.
  always_comb begin
    if (fifo_count_r != '0) data_out = mem_r[rd_ptr_r];
    else                    data_out = 8'h00;
  end

  assign data_out_valid = (fifo_count_r != '0);
  assign fifo_count     = fifo_count_r;
  assign overrun        = overrun_r;
  assign framing_err    = framing_err_r;

endmodule
